// File: rtl/float_to_int.sv
// rtl/float_to_int.sv - IEEE-754 single to int32 converter, truncating, iterative shifter
//
// Converts a single-precision float to a signed 32-bit integer, rounding
// toward zero. Handshake: exec_strobe_i starts a conversion from IDLE;
// done_strobe_o pulses one cycle once z_value_o/invalid_o are valid.
//
// Optional feature macro: FLOAT_TO_INT_SATURATE_EN
//   defined   : +overflow/+Inf -> 0x7FFFFFFF, -overflow/-Inf -> 0x80000000
//   undefined : every exception -> 0x80000000
//   NaN always gives 0x80000000; invalid_o is set for every exception.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_ni      in   asynchronous active-low reset
//   a_value_i     in   [31:0] float operand, sampled when a start is accepted
//   exec_strobe_i in   start request, honoured only in IDLE
//   z_value_o     out  [31:0] signed integer result (registered)
//   invalid_o     out  operand was NaN, Inf or out of int32 range
//   done_strobe_o out  one-cycle completion pulse

module float_to_int (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [31:0] a_value_i,
  input  logic        exec_strobe_i,
  output logic [31:0] z_value_o,
  output logic        invalid_o,
  output logic        done_strobe_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_PACK,
    ST_DONE
  } state_t;

  // Result class decided in UNPACK and consumed in PACK.
  typedef enum logic [1:0] {
    RES_NUM,
    RES_ZERO,
    RES_EXC,
    RES_NAN
  } res_t;

  state_t             state, state_next;
  logic [31:0]        a_q;
  logic               s_q;
  logic signed [9:0]  e_q;
  logic [31:0]        m_q;
  res_t               res_q;

  logic [7:0]         exp_w;
  logic [22:0]        frac_w;
  res_t               res_d;
  logic               need_align;
  logic [31:0]        exc_value;

  assign exp_w  = a_q[30:23];
  assign frac_w = a_q[22:0];

  // Classification of the latched operand. Biased exponent 158 is e==31,
  // where only exactly -2^31 is representable.
  always_comb begin
    res_d      = RES_NUM;
    need_align = 1'b0;
    if (exp_w == 8'd0) begin
      res_d = RES_ZERO;
    end else if (exp_w == 8'd255) begin
      res_d = (frac_w != 23'd0) ? RES_NAN : RES_EXC;
    end else if (exp_w < 8'd127) begin
      res_d = RES_ZERO;
    end else if (exp_w > 8'd158) begin
      res_d = RES_EXC;
    end else if (exp_w == 8'd158) begin
      res_d = (a_q[31] && frac_w == 23'd0) ? RES_NUM : RES_EXC;
    end else begin
      res_d      = RES_NUM;
      need_align = 1'b1;
    end
  end

`ifdef FLOAT_TO_INT_SATURATE_EN
  assign exc_value = s_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
  assign exc_value = 32'h8000_0000;
`endif

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (exec_strobe_i) state_next = ST_UNPACK;
      ST_UNPACK: state_next = need_align ? ST_ALIGN : ST_PACK;
      ST_ALIGN:  if (e_q == 10'sd30) state_next = ST_PACK;
      ST_PACK:   state_next = ST_DONE;
      // done_strobe_o doubles as the DONE phase bit: low on entry, high
      // for the second cycle, after which we leave.
      ST_DONE:   if (done_strobe_o) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      a_q           <= 32'd0;
      s_q           <= 1'b0;
      e_q           <= 10'sd0;
      m_q           <= 32'd0;
      res_q         <= RES_ZERO;
      z_value_o     <= 32'd0;
      invalid_o     <= 1'b0;
      done_strobe_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exec_strobe_i) a_q <= a_value_i;
        end
        ST_UNPACK: begin
          s_q   <= a_q[31];
          e_q   <= $signed({2'b00, exp_w}) - 10'sd127;
          // Hidden bit at position 31: the value sits at exponent 31.
          m_q   <= {1'b1, frac_w, 8'd0};
          res_q <= res_d;
        end
        ST_ALIGN: begin
          // Dropped bits truncate toward zero for both signs because the
          // shift acts on the magnitude.
          m_q <= m_q >> 1;
          e_q <= e_q + 10'sd1;
        end
        ST_PACK: begin
          case (res_q)
            RES_NUM:  z_value_o <= s_q ? (~m_q + 32'd1) : m_q;
            RES_ZERO: z_value_o <= 32'd0;
            RES_EXC:  z_value_o <= exc_value;
            default:  z_value_o <= 32'h8000_0000;
          endcase
          invalid_o <= (res_q == RES_EXC) || (res_q == RES_NAN);
        end
        ST_DONE: begin
          done_strobe_o <= ~done_strobe_o;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// tb/tb_float_to_int.sv - scoreboard bench for float_to_int with random and directed operands

module tb_float_to_int;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [31:0] a_value = 32'd0;
  logic        exec_strobe = 1'b0;
  logic [31:0] z_value;
  logic        invalid;
  logic        done_strobe;

  float_to_int dut (
    .clk           (clk),
    .reset_ni      (reset_ni),
    .a_value_i     (a_value),
    .exec_strobe_i (exec_strobe),
    .z_value_o     (z_value),
    .invalid_o     (invalid),
    .done_strobe_o (done_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    logic        inv;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ndone = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exc_val(input logic s);
`ifdef FLOAT_TO_INT_SATURATE_EN
    return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    return 32'h8000_0000;
`endif
  endfunction

  // Value-level reference: magnitude = 1.frac * 2^(exp-127), truncated,
  // then range-checked as a true signed integer.
  function automatic exp_t model(input logic [31:0] a);
    exp_t   r;
    logic   s;
    int     ex;
    int     e;
    longint mant;
    longint mag;
    longint val;
    s    = a[31];
    ex   = int'(a[30:23]);
    mant = longint'({1'b1, a[22:0]});
    r.a   = a;
    r.z   = 32'd0;
    r.inv = 1'b0;
    r.lat = 3;
    r.acc = 0;
    if (ex == 255) begin
      r.inv = 1'b1;
      r.z   = (a[22:0] != 0) ? 32'h8000_0000 : exc_val(s);
    end else if (ex >= 127) begin
      e = ex - 127;
      if (e >= 32) begin
        r.inv = 1'b1;
        r.z   = exc_val(s);
      end else begin
        mag = (e >= 23) ? (mant << (e - 23)) : (mant >> (23 - e));
        val = s ? -mag : mag;
        if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
          r.inv = 1'b1;
          r.z   = exc_val(s);
        end else begin
          r.z = val[31:0];
        end
        if (e <= 30) r.lat = 3 + (31 - e);
      end
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding start.
  always @(negedge clk) begin
    if (reset_ni && done_strobe) begin
      ndone <= ndone + 1;
      checks = checks + 1;
      if (prev_done) begin
        errors = errors + 1;
        $display("FAIL done_width: done high two cycles in a row, required one");
      end
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_done: done pulse with no outstanding start at cycle %0d", cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (z_value !== x.z || invalid !== x.inv || (cyc - x.acc) != x.lat) begin
          errors = errors + 1;
          $display("FAIL result a=%08h: got z=%08h inv=%0b lat=%0d, required z=%08h inv=%0b lat=%0d",
                   x.a, z_value, invalid, cyc - x.acc, x.z, x.inv, x.lat);
        end
      end
    end
    prev_done <= done_strobe;
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks = checks + 1;
    if (got !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %08h, required %08h", name, got, req);
    end
  endtask

  task automatic start(input logic [31:0] a, input bit hold);
    exp_t x;
    @(negedge clk);
    a_value     = a;
    exec_strobe = 1'b1;
    @(posedge clk);
    #1;
    x     = model(a);
    x.acc = cyc;
    sb.push_back(x);
    if (!hold) begin
      exec_strobe = 1'b0;
      a_value     = $urandom;
    end
  endtask

  task automatic wait_done();
    int n;
    int d0;
    n  = 0;
    d0 = ndone;
    while (ndone == d0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (ndone == d0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic conv(input logic [31:0] a);
    start(a, 1'b0);
    wait_done();
  endtask

  logic [31:0] directed [12] = '{
    32'h4049_0FDB, 32'hC2F6_E979, 32'h3F80_0000, 32'h3F7F_FFFF,
    32'h0000_0001, 32'h8000_0000, 32'hCF00_0000, 32'h4F00_0000,
    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'hFFC0_0000
  };

  initial begin
    int dn;
    logic [31:0] r;
    exp_t x;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_z", z_value, 32'd0);
    check_val("reset_inv", {31'd0, invalid}, 32'd0);
    check_val("reset_done", {31'd0, done_strobe}, 32'd0);
    reset_ni = 1'b1;

    foreach (directed[i]) conv(directed[i]);

    // Strobe held through a whole conversion: one restart only after DONE.
    start(32'h3F80_0000, 1'b1);
    wait_done();
    @(posedge clk);
    #1;
    x     = model(32'h3F80_0000);
    x.acc = cyc;
    sb.push_back(x);
    exec_strobe = 1'b0;
    wait_done();

    // Reset pulse mid-ALIGN after a nonzero result is on the outputs.
    conv(32'h4049_0FDB);
    start(32'h3F80_0000, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_ni = 1'b0;
    #1;
    void'(sb.pop_back());
    check_val("midreset_z", z_value, 32'd0);
    check_val("midreset_inv", {31'd0, invalid}, 32'd0);
    check_val("midreset_done", {31'd0, done_strobe}, 32'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    dn = ndone;
    repeat (40) @(posedge clk);
    check_val("no_residual_done", dn, ndone);
    conv(32'h4120_0000);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[30:23] = 8'($urandom_range(118, 160));
      conv(r);
    end

    repeat (5) @(posedge clk);
    check_val("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
# float_to_int

Multi-cycle converter from IEEE-754 single-precision float to signed 32-bit two's-complement integer, rounding toward zero (C cast semantics). It is the inverse companion of the FPU's integer-to-float unit and uses the same `exec_strobe_i`/`done_strobe_o` handshake, so the FPU sequencer drives both identically. It uses a small FSM and an iterative one-bit-per-cycle right shifter, trading latency for area.

## Interface
No parameters.
- `clk` input 1: clock, rising edge.
- `reset_ni` input 1: asynchronous, active-low reset.
- `a_value_i` input 32: float operand (sign, exp[30:23], frac[22:0]); sampled only on the edge where a start is accepted.
- `exec_strobe_i` input 1: start request; honoured only in IDLE.
- `z_value_o` output 32: signed integer result; registered.
- `invalid_o` output 1: set when the operand is NaN, ±Inf, or out of int32 range; valid with `z_value_o`.
- `done_strobe_o` output 1: one-cycle pulse; result is valid from this cycle until the next accepted start.

## Operation
- Reset values: state IDLE; `z_value_o` = 0; `invalid_o` = 0; `done_strobe_o` = 0. Internal registers are don't-care.
- Internal registers: sign `s`; signed 10-bit unbiased exponent `e`; 32-bit magnitude `m`.
- IDLE: when `exec_strobe_i`=1, latch `a_value_i` and go to UNPACK. Otherwise stay in IDLE.
- UNPACK: compute `e` = exp−127 and `m` = {1, frac, 8'b0}. This places the value at exponent 31. Decide the path:
  - exp==0 (±0 or denormal), or e<0: result 0, invalid=0, go to PACK. −0.0 → 0.
  - exp==255 (Inf or NaN): exception, go to PACK.
  - e>31: exception.
  - e==31: exactly −2^31 (s=1, frac=0) gives 0x80000000 with invalid=0. All other e==31 cases are an exception. Go to PACK.
  - 0≤e≤30: go to ALIGN.
- ALIGN: each cycle do `m` >>= 1 and `e`++. The cycle that shifts from e==30 to 31 also moves to PACK. ALIGN takes exactly k = 31−e cycles. Shifted-out bits are discarded, which truncates toward zero.
- PACK: write `z_value_o` = s ? −m : m, or the exception value. Write `invalid_o`. Go to DONE.
- DONE:
  - First cycle: assert `done_strobe_o`.
  - Next cycle: deassert it and return to IDLE.
  - `done_strobe_o` is therefore high for exactly one cycle.
- Exception value: see Configuration. NaN always gives 0x80000000, regardless of sign or configuration.
- Start arbitration: `exec_strobe_i` is ignored outside IDLE. A strobe in the same cycle that DONE returns to IDLE is ignored. It is accepted on the following cycle if still held.

## Timing
- Let edge 0 be the edge that accepts `exec_strobe_i`.
- `done_strobe_o` is high in the cycle after edge 3+k, where k = 31−e for the ALIGN path and k = 0 otherwise.
  - Minimum latency: 3 edges (zero, special, and e==31 paths).
  - Maximum latency: 34 edges (e==0, e.g. 1.0).
- `z_value_o` and `invalid_o` update at edge 2+k. This is one cycle before `done_strobe_o` rises. Both hold their values until the next PACK.
- Back-to-back throughput: the next start can be accepted no earlier than edge 5+k.
- Reset mid-operation: asserting `reset_ni` low at any point immediately forces IDLE and the reset output values. After release, the first strobe starts a fresh conversion. There is no residual pulse.

## Configuration
- `FLOAT_TO_INT_SATURATE_EN` defined:
  - Positive out-of-range values and +Inf give 0x7FFFFFFF.
  - Negative out-of-range values and −Inf give 0x80000000.
- `FLOAT_TO_INT_SATURATE_EN` undefined: every exception, including positive ones, gives 0x80000000 (integer-indefinite).
- In both configurations `invalid_o`=1 for every exception, and NaN gives 0x80000000.

## Test plan
- 0x40490FDB (3.14159) → 0x00000003, invalid 0. Done after edge 33 (e=1, k=30). Then 0xC2F6E979 (−123.456) → 0xFFFFFF85, invalid 0.
- 0x3F800000 (1.0) → 0x00000001 at maximum latency (done after edge 34). Also 0x3F7FFFFF → 0, 0x00000001 (denormal) → 0, and 0x80000000 (−0.0) → 0. The three zero-result cases are done after edge 3.
- 0xCF000000 (−2^31) → 0x80000000, invalid 0. 0x4F000000 (+2^31) → 0x7FFFFFFF with SATURATE_EN, 0x80000000 without; invalid 1 in both.
- 0x7F800000 (+Inf) → config-dependent as above, invalid 1. 0xFF800000 (−Inf) → 0x80000000, invalid 1. 0x7FC00000 and 0xFFC00000 (NaN) → 0x80000000, invalid 1, in both builds.
- Strobe held continuously during a conversion: no restart and exactly one done pulse per accepted start. Pulsing `reset_ni` low mid-ALIGN: outputs return to 0, done never fires. Then a new start with 0x41200000 (10.0) → 0x0000000A.
